sobel_stream_core: RTL and testbench

Parametrised successor to the single-width Sobel stage. It accepts a raster-scan AXI-Stream of grey pixels framed by start-of-frame and end-of-line markers, and keeps two line buffers. For each interior pixel it emits the L1 Sobel magnitude |Gx|+|Gy|, saturated to pixel width, or a binary edge map against a runtime threshold. It sits between the pixel unpacker and the output DMA stream in the image IP.

---
 rtl/sobel_pkg.sv | 22 ++
 rtl/sobel_line_buffer.sv | 25 ++
 rtl/sobel_stream_core.sv | 165 ++++++++++++++++
 tb/tb_sobel_stream_core.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge core.
package sobel_pkg;

    localparam logic SOBEL_MODE_MAG = 1'b0;
    localparam logic SOBEL_MODE_BIN = 1'b1;

    localparam int MAX_MAG_W = 15;

    function automatic int mag_width(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic logic [MAX_MAG_W-1:0] sat_mag(
        input logic [MAX_MAG_W-1:0] mag,
        input int                   pix_w
    );
        logic [MAX_MAG_W-1:0] lim;
        lim = MAX_MAG_W'((1 << pix_w) - 1);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line RAM, asynchronous read so the old word is seen
// in the same cycle the new one is written.
module sobel_line_buffer #(
    parameter int DEPTH = 32,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel: two line RAMs, a sliding window and a
// one-deep output register with valid/ready back-pressure.
module sobel_stream_core
    import sobel_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  mode,
    input  logic [PIX_W-1:0]      thresh,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_user,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_user,
    output logic                  m_last,
    output logic                  err_sync
);

    localparam int MW = mag_width(PIX_W);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    logic [CW-1:0] col_q, col_d, eff_col;
    logic [RW-1:0] row_q, row_d, eff_row;
    logic          err_q, err_d;
    logic          m_valid_q, m_valid_d;
    logic          m_user_q, m_user_d;
    logic          m_last_q, m_last_d;
    logic [PIX_W-1:0] res_q, res_d;

    logic             accept, at_eol, produce;
    logic [PIX_W-1:0] pix, lb0_rd, lb1_rd;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic [MW-1:0]    xp, xn, yp, yn, ax, ay, mag;
    logic signed [MW-1:0] gx, gy;
    logic             unused_hi;

    assign pix       = s_data[PIX_W-1:0];
    assign unused_hi = ^s_data[DATA_WIDTH-1:PIX_W];
    assign s_ready   = !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;

    // s_user re-anchors the raster regardless of where the counters are
    assign eff_col = s_user ? '0 : col_q;
    assign eff_row = s_user ? '0 : row_q;
    assign at_eol  = (eff_col == CW'(IMG_WIDTH - 1));
    assign produce = accept && (eff_row >= RW'(2)) && (eff_col >= CW'(2));

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb0 (
        .clk   (aclk),
        .we    (accept),
        .addr  (eff_col),
        .wdata (pix),
        .rdata (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb1 (
        .clk   (aclk),
        .we    (accept),
        .addr  (eff_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pix;
        end
    end

    // Kernel is evaluated on the post-shift window so the result
    // lands in the output register on the same accept edge.
    always_comb begin
        xp = MW'(win_d[0][2]) + (MW'(win_d[1][2]) << 1) + MW'(win_d[2][2]);
        xn = MW'(win_d[0][0]) + (MW'(win_d[1][0]) << 1) + MW'(win_d[2][0]);
        yp = MW'(win_d[2][0]) + (MW'(win_d[2][1]) << 1) + MW'(win_d[2][2]);
        yn = MW'(win_d[0][0]) + (MW'(win_d[0][1]) << 1) + MW'(win_d[0][2]);
        gx = $signed(xp - xn);
        gy = $signed(yp - yn);
        ax = gx[MW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[MW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag = ax + ay;
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        err_d     = err_q;
        m_valid_d = m_valid_q && !m_ready;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        res_d     = res_q;
        if (accept) begin
            if (s_last || at_eol) begin
                col_d = '0;
                row_d = (eff_row == RW'(IMG_HEIGHT - 1)) ? '0 : eff_row + 1'b1;
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
            if (s_last != at_eol) begin
                err_d = 1'b1;
            end
        end
        if (produce) begin
            m_valid_d = 1'b1;
            m_user_d  = (eff_row == RW'(2)) && (eff_col == CW'(2));
            m_last_d  = at_eol;
            if (mode == SOBEL_MODE_BIN) begin
                res_d = (mag >= MW'(thresh)) ? PIX_MAX : '0;
            end else begin
                res_d = PIX_W'(sat_mag(MAX_MAG_W'(mag), PIX_W));
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            col_q     <= '0;
            row_q     <= '0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_user_q  <= 1'b0;
            m_last_q  <= 1'b0;
            res_q     <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            err_q     <= err_d;
            m_valid_q <= m_valid_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
            res_q     <= res_d;
        end
    end

    always_ff @(posedge aclk) begin
        win_q <= win_d;
    end

    assign m_valid  = m_valid_q;
    assign m_user   = m_user_q;
    assign m_last   = m_last_q;
    assign m_data   = {{(DATA_WIDTH - PIX_W){1'b0}}, res_q};
    assign err_sync = err_q;

endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed-image bench for sobel_stream_core with a queue scoreboard
// and an independent output monitor.
module tb_sobel_stream_core;

    localparam int W = 32;
    localparam int H = 32;

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic        l;
    } exp_t;

    logic        aclk;
    logic        areset;
    logic        mode;
    logic [7:0]  thresh;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_user;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_user;
    logic        m_last;
    logic        err_sync;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;

    sobel_stream_core #(
        .PIX_W(8), .DATA_WIDTH(32), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .aclk(aclk), .areset(areset), .mode(mode), .thresh(thresh),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_user(s_user), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_user(m_user), .m_last(m_last), .err_sync(err_sync)
    );

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        m_ready = 1;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = 0;
                default: m_ready = 1;
            endcase
        end
    end

    function automatic logic [7:0] pix_of(input int img, input int c);
        case (img)
            1:       return (c < 16) ? 8'd0 : 8'd10;
            2:       return (c < 16) ? 8'd0 : 8'd255;
            default: return 8'(c);
        endcase
    endfunction

    // Ramp: Gx = 4(c+1) - 4(c-1) = 8. Steps: only centres 15/16 see 4*step.
    function automatic logic [7:0] exp_val(input int img, input int cc,
                                           input logic md, input logic [7:0] th);
        int mag;
        if (img == 0) mag = 8;
        else if (cc == 15 || cc == 16) mag = (img == 1) ? 40 : 1020;
        else mag = 0;
        if (md) return (mag >= int'(th)) ? 8'd255 : 8'd0;
        return (mag > 255) ? 8'd255 : 8'(mag);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial begin
        bit   hold_prev = 0;
        logic [31:0] pd;
        logic pu, pl;
        exp_t e;
        forever begin
            @(negedge aclk);
            if (areset) begin
                hold_prev = 0;
            end else begin
                check("s_ready", 32'(s_ready), 32'(!m_valid || m_ready));
                if (hold_prev)
                    check("hold", {m_valid, m_user, m_last, m_data[28:0]},
                          {1'b1, pu, pl, pd[28:0]});
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_out", 32'(m_valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("out", {m_user, m_last, m_data[29:0]},
                              {e.u, e.l, e.d[29:0]});
                        check("out_hi", {m_data[31:30]}, {e.d[31:30]});
                    end
                end
                hold_prev = m_valid && !m_ready;
                pd = m_data;
                pu = m_user;
                pl = m_last;
            end
        end
    end

    task automatic send_px(input logic [7:0] p, input logic u, input logic l);
        bit acc;
        int n;
        logic [23:0] junk;
        junk = 24'($urandom());
        s_valid = 1;
        s_data = {junk, p};
        s_user = u;
        s_last = l;
        n = 0;
        do begin
            @(negedge aclk);
            acc = s_ready;
            @(posedge aclk);
            n++;
        end while (!acc && n < 1000);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        #1;
        s_valid = 0;
        s_user = 0;
        s_last = 0;
    endtask

    task automatic run_frame(input int img, input int lr, input int lc,
                             input bit bad);
        exp_t e;
        for (int r = 0; r <= lr; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == lr && c > lc) break;
                if (r >= 2 && c >= 2) begin
                    e.d = {24'd0, exp_val(img, c - 1, mode, thresh)};
                    e.u = (r == 2 && c == 2);
                    e.l = (c == W - 1);
                    q.push_back(e);
                end
                send_px(pix_of(img, c), (r == 0 && c == 0),
                        (c == W - 1) || (bad && r == lr && c == lc));
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || m_valid) && n < 4000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        areset = 1;
        mode = 0;
        thresh = 0;
        s_valid = 0;
        s_data = 0;
        s_user = 0;
        s_last = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_outs", {27'd0, m_valid, m_user, m_last, err_sync, 1'b0},
              32'd0);
        check("rst_data", m_data, 32'd0);
        @(posedge aclk);
        #1;
        areset = 0;

        run_frame(0, H - 1, W - 1, 0);
        drain();
        run_frame(1, H - 1, W - 1, 0);
        drain();
        run_frame(2, H - 1, W - 1, 0);
        drain();
        mode = 1;
        thresh = 41;
        run_frame(1, H - 1, W - 1, 0);
        drain();
        thresh = 40;
        run_frame(1, H - 1, W - 1, 0);
        drain();
        mode = 0;
        ready_mode = 1;
        run_frame(0, H - 1, W - 1, 0);
        drain();
        ready_mode = 0;
        @(posedge aclk);
        #1;
        check("err_before", 32'(err_sync), 32'd0);

        run_frame(0, 5, 19, 0);
        check("err_mid", 32'(err_sync), 32'd0);
        run_frame(0, -1, 0, 0);
        begin
            exp_t e;
            e.d = 32'd8;
            e.u = 0;
            e.l = 0;
            q.push_back(e);
            send_px(pix_of(0, 20), 0, 1);
        end
        check("err_set", 32'(err_sync), 32'd1);
        drain();
        run_frame(0, H - 1, W - 1, 0);
        drain();
        check("err_sticky", 32'(err_sync), 32'd1);

        run_frame(0, 10, 9, 0);
        drain();
        ready_mode = 2;
        @(posedge aclk);
        #1;
        send_px(pix_of(0, 10), 0, 0);
        @(negedge aclk);
        check("pend_valid", 32'(m_valid), 32'd1);
        #3;
        areset = 1;
        #1;
        check("async_rst", {28'd0, m_valid, m_user, m_last, err_sync}, 32'd0);
        check("async_rst_data", m_data, 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 0;
        ready_mode = 0;
        run_frame(0, H - 1, W - 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
